// File: rtl/vblank_update_scheduler.sv
// vblank_update_scheduler: round-robin sharing of the vertical-blanking window among update engines
// Ports:
//   i_Clk, i_Rst_L         pixel clock, asynchronous active-low reset
//   i_Col_Count/Row_Count  free-running position from the sync generator
//   i_Req, i_Done          per-engine level request and completion strobe
//   i_Clear_Flags          synchronous clear of the sticky flags
//   o_Grant                registered one-hot (or zero) grant
//   o_Frame_Start          1-cycle pulse after position (0,0); o_Frame_Count counts them
//   o_Update_Window        registered vertical-blanking indicator
//   o_Timeout_Flag, o_Overrun, o_Missed_Flag  sticky error flags
module vblank_update_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int TOTAL_COLS  = 800,
  parameter int TOTAL_ROWS  = 525,
  parameter int ACTIVE_ROWS = 480,
  parameter int TIMEOUT     = 1024
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  input  logic [9:0]         i_Col_Count,
  input  logic [9:0]         i_Row_Count,
  input  logic [NUM_REQ-1:0] i_Req,
  input  logic [NUM_REQ-1:0] i_Done,
  input  logic               i_Clear_Flags,
  output logic [NUM_REQ-1:0] o_Grant,
  output logic               o_Frame_Start,
  output logic               o_Update_Window,
  output logic [NUM_REQ-1:0] o_Timeout_Flag,
  output logic               o_Overrun,
  output logic [NUM_REQ-1:0] o_Missed_Flag,
  output logic [15:0]        o_Frame_Count
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, SCAN, BUSY} state_t;
  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, served_q, served_d, to_q, to_d, miss_q, miss_d;
  logic [NUM_REQ-1:0] cand, to_set, miss_set;
  logic [PW-1:0]      idx_q, idx_d, ptr_q, ptr_d, pick;
  logic [TW-1:0]      timer_q, timer_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               win_q, win_d, fs_q, fs_d, ov_q, ov_d;
  logic               sof, close, found, valid, fin, ov_set;
  always_comb begin
    sof   = (i_Col_Count == 10'd0) && (i_Row_Count == 10'd0);
    // out-of-range coordinates hold the window rather than glitching it
    valid = (32'(i_Row_Count) < TOTAL_ROWS) && (32'(i_Col_Count) < TOTAL_COLS);
    win_d = valid ? (32'(i_Row_Count) >= ACTIVE_ROWS) : win_q;
    fs_d  = sof;
    cnt_d = cnt_q + 16'(sof);
    close = win_q & ~win_d;
    cand  = i_Req & ~served_q;
    found = 1'b0;
    pick  = '0;
    // downward sweep so the smallest offset from the pointer wins
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (cand[(32'(ptr_q) + 32'(k)) % NUM_REQ]) begin
        found = 1'b1;
        pick  = PW'((32'(ptr_q) + 32'(k)) % NUM_REQ);
      end
    fin      = i_Done[idx_q] || (timer_q == TW'(TIMEOUT - 1));
    state_d  = state_q;
    grant_d  = grant_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    timer_d  = timer_q;
    served_d = sof ? '0 : served_q;
    to_set   = '0;
    miss_set = '0;
    ov_set   = 1'b0;
    if (close) begin
      state_d  = IDLE;
      grant_d  = '0;
      ov_set   = (state_q == BUSY);
      miss_set = cand;
    end else if (state_q == IDLE) begin
      state_d = win_q ? SCAN : IDLE;
    end else if (state_q == SCAN) begin
      if (found) begin
        state_d = BUSY;
        grant_d = NUM_REQ'(1) << pick;
        idx_d   = pick;
        timer_d = '0;
      end
    end else begin
      timer_d = timer_q + TW'(1);
      if (fin) begin
        state_d  = SCAN;
        grant_d  = '0;
        served_d = served_d | grant_q;
        ptr_d    = (idx_q == PW'(NUM_REQ - 1)) ? '0 : idx_q + PW'(1);
        to_set   = i_Done[idx_q] ? '0 : grant_q;
      end
    end
    // a set in the same cycle as a clear survives
    to_d   = (i_Clear_Flags ? '0 : to_q) | to_set;
    miss_d = (i_Clear_Flags ? '0 : miss_q) | miss_set;
    ov_d   = (~i_Clear_Flags & ov_q) | ov_set;
  end
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      served_q <= '0;
      idx_q    <= '0;
      ptr_q    <= '0;
      timer_q  <= '0;
      win_q    <= 1'b0;
      fs_q     <= 1'b0;
      cnt_q    <= '0;
      to_q     <= '0;
      miss_q   <= '0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      served_q <= served_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      timer_q  <= timer_d;
      win_q    <= win_d;
      fs_q     <= fs_d;
      cnt_q    <= cnt_d;
      to_q     <= to_d;
      miss_q   <= miss_d;
      ov_q     <= ov_d;
    end
  end
  assign o_Grant         = grant_q;
  assign o_Frame_Start   = fs_q;
  assign o_Update_Window = win_q;
  assign o_Timeout_Flag  = to_q;
  assign o_Overrun       = ov_q;
  assign o_Missed_Flag   = miss_q;
  assign o_Frame_Count   = cnt_q;
endmodule

// File: doc/vblank_update_scheduler.md
Name: vblank_update_scheduler

Overview:
- Shares the vertical-blanking interval among NUM_REQ game-state update engines (ship, meteors, bullets, score) with round-robin arbitration.
- Consumes the free-running column/row counts from the VGA sync-pulse generator.
- Grants at most one engine at a time, and each engine at most once per frame, so frame-state writes never overlap active video.
- Flags engines that time out, overrun the window or are starved.

Parameters:
- NUM_REQ, 4: number of update engines (2..8).
- TOTAL_COLS, 800: columns per line, including blanking.
- TOTAL_ROWS, 525: rows per frame, including blanking.
- ACTIVE_ROWS, 480: visible rows; blanking starts at row ACTIVE_ROWS.
- TIMEOUT, 1024: maximum cycles a grant may be held (>=2).

Ports:
- i_Clk  in  1  pixel clock
- i_Rst_L  in  1  asynchronous active-low reset
- i_Col_Count  in  10  current column from sync generator
- i_Row_Count  in  10  current row from sync generator
- i_Req  in  NUM_REQ  per-engine update request, level
- i_Done  in  NUM_REQ  per-engine completion strobe
- i_Clear_Flags  in  1  synchronous clear of all sticky flags
- o_Grant  out  NUM_REQ  one-hot (or zero) grant, registered
- o_Frame_Start  out  1  1-cycle pulse at frame start
- o_Update_Window  out  1  high during vertical blanking
- o_Timeout_Flag  out  NUM_REQ  sticky: engine exceeded TIMEOUT
- o_Overrun  out  1  sticky: window closed while a grant was held
- o_Missed_Flag  out  NUM_REQ  sticky: request pending but unserved at window close
- o_Frame_Count  out  16  frames elapsed, wraps

Behaviour:
- Reset (i_Rst_L low, asynchronous): all outputs 0, state IDLE, served mask 0, RR pointer 0, timer 0.
- o_Frame_Start is registered: high for 1 cycle, on the cycle after Col==0 && Row==0.
- o_Frame_Count increments on that same cycle. 0xFFFF wraps to 0.
- o_Update_Window is registered: equals (Row >= ACTIVE_ROWS) delayed one cycle.
- Window close event: o_Update_Window is 1 and the next registered value is 0.
- Served mask clears to 0 on o_Frame_Start.
- FSM, IDLE: wait for o_Update_Window=1, then go to SCAN.
- FSM, SCAN (1 cycle per evaluation):
  - Candidates are i_Req & ~served.
  - Pick the first candidate searching upward from the RR pointer, wrapping modulo NUM_REQ.
  - If a candidate is found: o_Grant = onehot(idx) from the next cycle, timer=0, go to BUSY.
  - If none: stay in SCAN.
- FSM, BUSY: grant held constant; timer increments each cycle.
  - i_Done[idx]=1: grant drops the next cycle, served[idx] set, pointer = (idx+1) mod NUM_REQ, go to SCAN.
  - Timer reaches TIMEOUT-1 without done: same as done, and o_Timeout_Flag[idx] is also set.
  - i_Done bits of non-granted engines are ignored.
- Window close in any state:
  - Next cycle o_Grant=0 and state IDLE.
  - If in BUSY, o_Overrun is set and the engine is not marked served.
  - For every i with i_Req[i] & ~served[i] at close, o_Missed_Flag[i] is set.
- Simultaneous events:
  - Window close takes priority over done and timeout in the same cycle. Done is ignored; overrun is set.
  - i_Clear_Flags and a flag-set event in the same cycle: the set wins.
- Grant latency: request seen in SCAN at cycle t gives o_Grant at t+1. From done at cycle t, the next grant comes no earlier than t+2.
- Dropped request: if i_Req[idx] falls while granted, the grant is held until done, timeout or close. Engines must hold req until done.
- At most one o_Grant bit is high in any cycle, and o_Grant is 0 whenever o_Update_Window=0.
- The RR pointer persists across frames for fairness.
- Reset asserted mid-grant: o_Grant clears immediately (asynchronously); no flags set.

Test Plan:
- Reset, then run counters to Row=480/Col=0 with i_Req=4'b1111 and each engine asserting done 10 cycles after its grant:
  - Grants in order 0001, 0010, 0100, 1000, once each.
  - No grants in the next frame's active region.
  - o_Frame_Count=1 after the first Row=0/Col=0.
- Engine 2 never asserts done, i_Req=4'b0100:
  - Grant held exactly TIMEOUT=1024 cycles, then drops.
  - o_Timeout_Flag=0100; no re-grant in this frame.
- Engine 1 granted at Row=524/Col=790 with no done:
  - Grant drops the cycle after o_Update_Window falls.
  - o_Overrun=1.
  - o_Missed_Flag=0010 if it is still requesting.
- Fairness: frame 1 serves only engine 0 (window closes during it).
  - Frame 2 with i_Req=4'b0011: first grant is 0010, pointer = 1.
- Done and window close in the same cycle: o_Overrun=1, engine not marked served.
  - i_Clear_Flags pulse the next cycle clears all flags to 0.
- i_Rst_L low while BUSY: o_Grant=0 and o_Frame_Count=0 within the same cycle; after release, state IDLE.
